// File: rtl/sqrt_feeder.sv
// sqrt_feeder: valid/ready front end for the structural square-root core.
// Each accepted operand is held on core_valor_o, and the core is restarted for one cycle.
// Stale core status is masked for SETTLE_CYC cycles. The root is then captured when
// core_ready_i reaches DONE_LEVEL, or the operation is aborted once TIMEOUT RUN cycles elapse.
// The result, operand, RUN-cycle count and abort flag are held on the output stream until taken.
module sqrt_feeder #(
    parameter int unsigned DATA_W     = 16,
    parameter logic        DONE_LEVEL = 1'b0,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned CNT_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic [DATA_W-1:0]     core_valor_o,
    output logic                  core_rst_n_o,
    input  logic                  core_ready_i,
    input  logic [DATA_W/2-1:0]   core_root_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W/2-1:0]   out_root_o,
    output logic [DATA_W-1:0]     out_operand_o,
    output logic [CNT_W-1:0]      out_cycles_o,
    output logic                  out_timeout_o
);

    localparam int unsigned ROOT_W = DATA_W / 2;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StRun    = 3'd3;
    localparam logic [2:0] StOut    = 3'd4;

    localparam logic [2:0]       SettleLast = 3'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    logic [2:0]        state_q, state_d;
    logic [2:0]        settle_q, settle_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] valor_q, valor_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              timeout_q, timeout_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              core_done;

    // Saturating RUN-cycle count including the current cycle
    assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    assign core_done = (core_ready_i == DONE_LEVEL);

    // Next-state and datapath capture
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        valor_d   = valor_q;
        root_d    = root_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    valor_d = in_data_i;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                settle_d = 3'd0;
                cnt_d    = '0;
                state_d  = StSettle;
            end
            StSettle: begin
                // core_ready_i may still show the previous operation's result here
                cnt_d = '0;
                if (settle_q == SettleLast) begin
                    state_d = StRun;
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            StRun: begin
                cnt_d = cnt_inc;
                if (core_done) begin
                    root_d    = core_root_i;
                    cycles_d  = cnt_inc;
                    timeout_d = 1'b0;
                    state_d   = StOut;
                end else if (cnt_inc == TimeoutVal) begin
                    root_d    = '0;
                    cycles_d  = TimeoutVal;
                    timeout_d = 1'b1;
                    state_d   = StOut;
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Core restart is low for exactly the LOAD cycle; registered so the pin never glitches
    assign core_rst_n_d = (state_d != StLoad);

    // State and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            settle_q     <= 3'd0;
            cnt_q        <= '0;
            valor_q      <= '0;
            root_q       <= '0;
            cycles_q     <= '0;
            timeout_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            cnt_q        <= cnt_d;
            valor_q      <= valor_d;
            root_q       <= root_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign in_ready_o    = (state_q == StIdle);
    assign out_valid_o   = (state_q == StOut);
    assign core_valor_o  = valor_q;
    assign core_rst_n_o  = core_rst_n_q;
    assign out_root_o    = root_q;
    assign out_operand_o = valor_q;
    assign out_cycles_o  = cycles_q;
    assign out_timeout_o = timeout_q;

endmodule

// File: tb/tb_sqrt_feeder.sv
// Directed bench for sqrt_feeder, with a behavioural sqrt core behind it.
module tb_sqrt_feeder;

    localparam logic DONE_LEVEL = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] in_data_i = '0;
    logic [15:0] core_valor_o;
    logic        core_rst_n_o;
    logic        core_ready_i;
    logic [7:0]  core_root_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  out_root_o;
    logic [15:0] out_operand_o;
    logic [10:0] out_cycles_o;
    logic        out_timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    sqrt_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .core_valor_o (core_valor_o),
        .core_rst_n_o (core_rst_n_o),
        .core_ready_i (core_ready_i),
        .core_root_i  (core_root_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_root_o   (out_root_o),
        .out_operand_o(out_operand_o),
        .out_cycles_o (out_cycles_o),
        .out_timeout_o(out_timeout_o)
    );

    always #5 clk = ~clk;

    // Core model: mode 0 = done once restart is released for more than mdl_lat cycles,
    // mode 1 = status stuck at done, mode 2 = never done.
    int mdl_cnt  = 0;
    int mdl_lat  = 1;
    int mdl_mode = 0;

    always @(negedge clk) begin
        if (!core_rst_n_o) mdl_cnt = 0;
        else if (mdl_cnt < 100000) mdl_cnt = mdl_cnt + 1;
    end

    function automatic logic [7:0] isqrt(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 1; i < 256; i++) begin
            if (i * i <= int'(v)) r = i;
        end
        return 8'(r);
    endfunction

    assign core_ready_i = ((mdl_mode == 1) || (mdl_mode == 0 && mdl_cnt > mdl_lat)) ?
                          DONE_LEVEL : ~DONE_LEVEL;
    assign core_root_i  = isqrt(core_valor_o);

    typedef struct {
        logic [15:0] operand;
        int          lat;
        int          mode;
        logic [7:0]  exp_root;
        int          exp_cycles;
        logic        exp_to;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Full operation with out_ready_i held high; starts and ends on a negedge in IDLE
    task automatic do_op(input vec_t v);
        int n;
        bit busy_ok;
        mdl_lat    = v.lat;
        mdl_mode   = v.mode;
        in_data_i  = v.operand;
        in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", in_ready_o, 1);
        @(negedge clk);
        in_valid_i = 1'b0;
        in_data_i  = 16'($urandom);
        check("load_rst_low", core_rst_n_o, 0);
        check("load_valor", core_valor_o, v.operand);
        check("load_not_ready", in_ready_o, 0);
        @(negedge clk);
        check("settle_rst_high", core_rst_n_o, 1);
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid_o && n < 1100) begin
            if (in_ready_o) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("latency", n, v.exp_cycles + 1);
        check("busy_no_ready", busy_ok, 1);
        check("out_root", out_root_o, v.exp_root);
        check("out_operand", out_operand_o, v.operand);
        check("out_cycles", out_cycles_o, v.exp_cycles);
        check("out_timeout", out_timeout_o, v.exp_to);
        check("out_not_ready", in_ready_o, 0);
        @(negedge clk);
        check("out_drop", out_valid_o, 0);
        check("idle_ready", in_ready_o, 1);
    endtask

    initial begin
        int n;
        bit ok;
        vec_t rec;

        vecs[0] = '{operand: 16'd65535, lat: 8,  mode: 0, exp_root: 8'd255, exp_cycles: 8,
                    exp_to: 1'b0};
        vecs[1] = '{operand: 16'd0,     lat: 3,  mode: 0, exp_root: 8'd0,   exp_cycles: 3,
                    exp_to: 1'b0};
        vecs[2] = '{operand: 16'd1,     lat: 1,  mode: 0, exp_root: 8'd1,   exp_cycles: 1,
                    exp_to: 1'b0};
        vecs[3] = '{operand: 16'd2,     lat: 5,  mode: 0, exp_root: 8'd1,   exp_cycles: 5,
                    exp_to: 1'b0};
        vecs[4] = '{operand: 16'd144,   lat: 2,  mode: 0, exp_root: 8'd12,  exp_cycles: 2,
                    exp_to: 1'b0};
        vecs[5] = '{operand: 16'd65025, lat: 10, mode: 0, exp_root: 8'd255, exp_cycles: 10,
                    exp_to: 1'b0};
        // Status stuck at done through LOAD/SETTLE: completes on the first RUN cycle
        vecs[6] = '{operand: 16'd144,   lat: 7,  mode: 1, exp_root: 8'd12,  exp_cycles: 1,
                    exp_to: 1'b0};
        // Core never finishes: watchdog abort
        vecs[7] = '{operand: 16'd65535, lat: 0,  mode: 2, exp_root: 8'd0,   exp_cycles: 1023,
                    exp_to: 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_timeout", out_timeout_o, 0);
        check("rst_core_rst_n", core_rst_n_o, 0);
        check("rst_out_root", out_root_o, 0);
        check("rst_out_cycles", out_cycles_o, 0);
        check("rst_out_operand", out_operand_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready_o, 1);
        check("rel_core_rst_n", core_rst_n_o, 1);

        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // Output backpressure with a hostile input stream
        out_ready_i = 1'b0;
        mdl_mode    = 0;
        mdl_lat     = 4;
        in_data_i   = 16'd2025;
        in_valid_i  = 1'b1;
        @(negedge clk);
        n = 0;
        while (!out_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", out_valid_o, 1);
        check("bp_root", out_root_o, 45);
        check("bp_cycles", out_cycles_o, 4);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data_i = i[0] ? 16'h5555 : 16'hAAAA;
            @(negedge clk);
            if (out_valid_o !== 1'b1 || out_root_o !== 8'd45 || out_operand_o !== 16'd2025 ||
                out_cycles_o !== 11'd4 || out_timeout_o !== 1'b0 || in_ready_o !== 1'b0 ||
                core_valor_o !== 16'd2025) ok = 1'b0;
        end
        check("bp_stable", ok, 1);
        in_data_i   = 16'd10000;
        mdl_lat     = 3;
        out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_hs_drop", out_valid_o, 0);
        check("bp_hs_ready", in_ready_o, 1);
        @(negedge clk);
        in_valid_i = 1'b0;
        check("bp_next_rst_low", core_rst_n_o, 0);
        check("bp_next_valor", core_valor_o, 10000);
        n = 0;
        while (!out_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_root", out_root_o, 100);
        check("bp_next_cycles", out_cycles_o, 3);
        @(negedge clk);

        // Reset mid-RUN discards the operation
        mdl_lat    = 20;
        in_data_i  = 16'd144;
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_run_rst_n", core_rst_n_o, 1);
        rst_n = 1'b0;
        #1;
        check("async_core_rst", core_rst_n_o, 0);
        check("async_out_valid", out_valid_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready_o, 1);
        check("post_rst_core_rst_n", core_rst_n_o, 1);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid_o !== 1'b0) ok = 1'b0;
        end
        check("no_stale_result", ok, 1);
        rec = '{operand: 16'd9, lat: 2, mode: 0, exp_root: 8'd3, exp_cycles: 2, exp_to: 1'b0};
        do_op(rec);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/sqrt_feeder.md
Name: sqrt_feeder

Overview:
Stream adapter that sits directly upstream of the structural square-root top (16-bit operand in, 8-bit root out).
- Accepts operands over a valid/ready input stream.
- Drives the core's operand and restart (core active-low reset) pins, then waits for the core's completion level.
- Captures the root, measures latency, and presents the result on a valid/ready output stream.
- A watchdog aborts hung operations.

Parameters:
DATA_W, 16, operand width; root width is DATA_W/2.
DONE_LEVEL, 1'b0, level of core_ready_i that means "root valid".
SETTLE_CYC, 1, cycles after core restart during which core_ready_i is ignored; legal range 1..7.
TIMEOUT, 1023, maximum RUN cycles before abort; must fit in CNT_W.
CNT_W, 11, width of the latency counter.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid_i  in  1  operand valid.
in_ready_o  out  1  feeder can accept an operand.
in_data_i  in  DATA_W  operand.
core_valor_o  out  DATA_W  operand driven to the sqrt core.
core_rst_n_o  out  1  active-low restart to the sqrt core.
core_ready_i  in  1  core status; equals DONE_LEVEL when the root is valid.
core_root_i  in  DATA_W/2  root from the core.
out_valid_o  out  1  result valid.
out_ready_i  in  1  consumer accepts result.
out_root_o  out  DATA_W/2  captured root; 0 on timeout.
out_operand_o  out  DATA_W  operand that produced the result.
out_cycles_o  out  CNT_W  RUN-state cycle count for this operation.
out_timeout_o  out  1  result was aborted by the watchdog.

Behaviour:
- Reset, asynchronous:
  - state = IDLE; all data and count registers = 0; out_valid_o = 0; out_timeout_o = 0.
  - core_rst_n_o = 0 while rst_n = 0 (asynchronous path), and 1 in IDLE after release.
  - in_ready_o = 1 from the first cycle after release.
- States: IDLE, LOAD, SETTLE, RUN, OUT.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i & in_ready_o at edge k: register in_data_i into core_valor_o and out_operand_o, go to LOAD.
- LOAD, exactly 1 cycle:
  - core_rst_n_o = 0, in_ready_o = 0.
  - core_valor_o is stable from LOAD until the next accept.
- SETTLE, SETTLE_CYC cycles:
  - core_rst_n_o = 1; core_ready_i ignored (stale status from the previous operation must not complete the new one).
  - Counter cleared to 0.
- RUN:
  - Counter increments every cycle.
  - If core_ready_i == DONE_LEVEL: capture core_root_i into out_root_o, out_cycles_o = counter+1 (includes the done cycle), out_timeout_o = 0, go to OUT.
  - Else if counter+1 == TIMEOUT: out_root_o = 0, out_cycles_o = TIMEOUT, out_timeout_o = 1, go to OUT.
  - Done and timeout in the same cycle: done wins.
- OUT:
  - out_valid_o = 1; all out_* outputs held stable while out_ready_i = 0.
  - On out_valid_o & out_ready_i: out_valid_o = 0 next cycle, go to IDLE.
  - in_ready_o = 0 in OUT; no overlap between operations.
- Minimum operation latency: accept edge to out_valid_o = 3 + SETTLE_CYC - 1 edges when done is seen on the first RUN cycle.
- Back-to-back throughput: one operation per (core latency + SETTLE_CYC + 3) cycles.
- in_data_i is ignored outside IDLE; in_valid_i may drop at any time without effect unless handshaken.
- Counter saturates at its maximum value (all ones); it never wraps.
- rst_n asserted in any state: immediate return to IDLE and the in-flight result is discarded.
- A pending OUT result is lost on reset; no partial output is produced.

Test Plan:
- Reset released, in_data_i = 65535 with core returning done and root 255 after 8 RUN cycles -> core_rst_n_o low for exactly 1 cycle; out_valid_o with out_root_o = 255, out_operand_o = 65535, out_cycles_o = 8, out_timeout_o = 0.
- Stream 0, 1, 2, 144, 65025 with out_ready_i = 1 -> roots 0, 1, 1, 12, 255 in order; in_ready_o low from each accept until the corresponding out handshake.
- core_ready_i held at DONE_LEVEL through LOAD and SETTLE, then continuing -> no completion before RUN; out_cycles_o = 1.
- core_ready_i never reaches DONE_LEVEL -> after TIMEOUT = 1023 RUN cycles: out_timeout_o = 1, out_root_o = 0, out_cycles_o = 1023.
- out_ready_i held 0 for 20 cycles in OUT with in_valid_i = 1 and in_data_i toggling -> out_* stable; no new accept; accept resumes the cycle after the out handshake.
- rst_n pulsed low mid-RUN for operand 144 -> core_rst_n_o = 0 immediately; out_valid_o = 0; IDLE with in_ready_o = 1 after release; no result for 144 appears.
